// File: rtl/rt_isect_scheduler_if.sv
// Requester, intersect-pipe and response signals of rt_isect_scheduler.
// The master side is the environment (requesters plus pipe); the scheduler takes the slave side.
interface rt_isect_scheduler_if #(
    parameter int unsigned W    = 32,
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*12*W-1:0] req_data;
    logic                 pipe_valid;
    logic [12*W-1:0]      pipe_data;
    logic                 pipe_hit;
    logic [W-1:0]         pipe_t_near;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [NREQ-1:0]      rsp_hit;
    logic [NREQ*W-1:0]    rsp_t_near;

    modport master (
        output req_valid, req_data, pipe_hit, pipe_t_near, rsp_ready,
        input  req_ready, pipe_valid, pipe_data, rsp_valid, rsp_hit, rsp_t_near
    );

    modport slave (
        input  req_valid, req_data, pipe_hit, pipe_t_near, rsp_ready,
        output req_ready, pipe_valid, pipe_data, rsp_valid, rsp_hit, rsp_t_near
    );
endinterface

// File: rtl/rt_isect_scheduler.sv
// Round-robin scheduler sharing one fixed-latency ray/box intersect pipe among NREQ requesters.
// Results are steered by a tag line into per-requester FIFOs whose space is reserved by credits.
module rt_isect_scheduler #(
    parameter int unsigned W         = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned PIPE_LAT  = 4,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    rt_isect_scheduler_if.slave bus,
    output logic                busy,
    output logic [31:0]         issue_count,
    output logic [31:0]         hit_count
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned DW = 12 * W;

    typedef struct packed {
        logic         hit;
        logic [W-1:0] t_near;
    } rsp_entry_t;

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    credit_q [NREQ];
    logic [CW-1:0]    credit_d [NREQ];
    logic [CW-1:0]    cnt_q    [NREQ];
    logic [CW-1:0]    cnt_d    [NREQ];
    logic [PW-1:0]    rd_ptr_q [NREQ];
    logic [PW-1:0]    rd_ptr_d [NREQ];
    logic [PW-1:0]    wr_ptr_q [NREQ];
    logic [PW-1:0]    wr_ptr_d [NREQ];
    rsp_entry_t       mem_q    [NREQ][RSP_DEPTH];
    rsp_entry_t       mem_d    [NREQ][RSP_DEPTH];
    logic             pipe_valid_q, pipe_valid_d;
    logic [IW-1:0]    pipe_id_q, pipe_id_d;
    logic [DW-1:0]    pipe_data_q, pipe_data_d;
    logic [PIPE_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [IW-1:0]    tag_id_q [PIPE_LAT];
    logic [IW-1:0]    tag_id_d [PIPE_LAT];
    logic [31:0]      issue_cnt_q, issue_cnt_d;
    logic [31:0]      hit_cnt_q, hit_cnt_d;

    logic [NREQ-1:0]  elig_c;
    logic [DW-1:0]    req_word_c [NREQ];
    logic [IW-1:0]    scan_idx_c;
    logic             grant_vld_c;
    logic [IW-1:0]    grant_id_c;
    logic             push_vld_c;
    logic [IW-1:0]    push_id_c;
    logic [NREQ-1:0]  push_c, pop_c, issue_c, nonempty_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Round-robin arbiter: downward scan so the first eligible slot from ptr wins.
    always_comb begin
        elig_c      = '0;
        scan_idx_c  = '0;
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig_c[i]     = enable & bus.req_valid[i] & (credit_q[i] != '0);
            req_word_c[i] = bus.req_data[i*DW +: DW];
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx_c = IW'((int'(ptr_q) + k) % int'(NREQ));
            if (elig_c[scan_idx_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = scan_idx_c;
            end
        end
        bus.req_ready = grant_vld_c ? (NREQ'(1) << grant_id_c) : '0;
    end

    // Issue register, tag line, FIFO/credit bookkeeping and counters.
    always_comb begin
        ptr_d        = ptr_q;
        pipe_valid_d = grant_vld_c;
        pipe_id_d    = grant_id_c;
        pipe_data_d  = grant_vld_c ? req_word_c[grant_id_c] : '0;
        issue_cnt_d  = issue_cnt_q + 32'(grant_vld_c);
        push_vld_c   = tag_valid_q[PIPE_LAT-1];
        push_id_c    = tag_id_q[PIPE_LAT-1];
        hit_cnt_d    = hit_cnt_q + 32'(push_vld_c & bus.pipe_hit);
        mem_d        = mem_q;
        push_c       = '0;
        pop_c        = '0;
        issue_c      = '0;

        if (grant_vld_c) begin
            ptr_d = (grant_id_c == IW'(NREQ - 1)) ? '0 : grant_id_c + IW'(1);
        end

        tag_valid_d[0] = pipe_valid_q;
        tag_id_d[0]    = pipe_id_q;
        for (int k = 1; k < PIPE_LAT; k++) begin
            tag_valid_d[k] = tag_valid_q[k-1];
            tag_id_d[k]    = tag_id_q[k-1];
        end

        for (int i = 0; i < NREQ; i++) begin
            push_c[i]   = push_vld_c && (push_id_c == IW'(i));
            pop_c[i]    = (cnt_q[i] != '0) && bus.rsp_ready[i];
            issue_c[i]  = grant_vld_c && (grant_id_c == IW'(i));
            rd_ptr_d[i] = pop_c[i] ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            wr_ptr_d[i] = push_c[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            if (push_c[i]) begin
                mem_d[i][wr_ptr_q[i]] = '{hit: bus.pipe_hit, t_near: bus.pipe_t_near};
            end
            cnt_d[i]    = cnt_q[i] + CW'(push_c[i]) - CW'(pop_c[i]);
            credit_d[i] = credit_q[i] - CW'(issue_c[i]) + CW'(pop_c[i]);
        end
    end

    // Response heads are forced to zero while a FIFO is empty.
    always_comb begin
        nonempty_c     = '0;
        bus.rsp_valid  = '0;
        bus.rsp_hit    = '0;
        bus.rsp_t_near = '0;
        for (int i = 0; i < NREQ; i++) begin
            nonempty_c[i] = (cnt_q[i] != '0);
            if (nonempty_c[i]) begin
                bus.rsp_valid[i]          = 1'b1;
                bus.rsp_hit[i]            = mem_q[i][rd_ptr_q[i]].hit;
                bus.rsp_t_near[i*W +: W]  = mem_q[i][rd_ptr_q[i]].t_near;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_id_q    <= '0;
            pipe_data_q  <= '0;
            tag_valid_q  <= '0;
            issue_cnt_q  <= '0;
            hit_cnt_q    <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= CW'(RSP_DEPTH);
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_id_q    <= pipe_id_d;
            pipe_data_q  <= pipe_data_d;
            tag_valid_q  <= tag_valid_d;
            issue_cnt_q  <= issue_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            for (int k = 0; k < PIPE_LAT; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= credit_d[i];
                cnt_q[i]    <= cnt_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
            end
        end
    end

    // Storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.pipe_valid = pipe_valid_q;
    assign bus.pipe_data  = pipe_data_q;
    assign issue_count    = issue_cnt_q;
    assign hit_count      = hit_cnt_q;
    assign busy           = pipe_valid_q | (|tag_valid_q) | (|nonempty_c);

endmodule

// File: tb/tb_rt_isect_scheduler.sv
// Scoreboard bench for rt_isect_scheduler driving a behavioural 4-cycle slab-test pipe.
module tb_rt_isect_scheduler;
    localparam int unsigned W         = 32;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned PIPE_LAT  = 4;
    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned DW        = 12 * W;
    localparam logic [W-1:0] B0      = 32'h0000_8000;
    localparam logic [W-1:0] B1      = 32'h0001_8000;
    localparam logic [W-1:0] ONE     = 32'h0001_0000;
    localparam logic [W-1:0] TWO     = 32'h0002_0000;
    localparam logic [W-1:0] NEG_ONE = 32'hFFFF_0000;

    typedef struct {
        int           id;
        logic [W:0]   v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [31:0] issue_count;
    logic [31:0] hit_count;

    logic [DW-1:0] req_word [NREQ];
    logic [W:0]    pstage   [PIPE_LAT];
    exp_t          sb[$];
    int            glog[$];
    int            last_hs_cyc [NREQ];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    rt_isect_scheduler_if #(.W(W), .NREQ(NREQ)) bus ();

    rt_isect_scheduler #(
        .W(W), .NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus),
        .busy(busy), .issue_count(issue_count), .hit_count(hit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Q16.16 slab test: returns {hit, t_near}.
    function automatic logic [W:0] aabb(input logic [DW-1:0] d);
        longint o, inv, b0, b1, t0, t1, tn, tf;
        tn = -(64'sd1 <<< 62);
        tf = (64'sd1 <<< 62);
        for (int a = 0; a < 3; a++) begin
            o   = longint'($signed(d[(11-a)*W +: W]));
            inv = longint'($signed(d[(8-a)*W +: W]));
            b0  = longint'($signed(d[(5-a)*W +: W]));
            b1  = longint'($signed(d[(2-a)*W +: W]));
            t0  = ((b0 - o) * inv) >>> 16;
            t1  = ((b1 - o) * inv) >>> 16;
            if (t0 > t1) begin
                o = t0; t0 = t1; t1 = o;
            end
            if (t0 > tn) tn = t0;
            if (t1 < tf) tf = t1;
        end
        return {(tn <= tf) && (tf >= 0), W'(tn)};
    endfunction

    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = req_word[i];
    end

    // Behavioural intersect pipe sharing rst with the scheduler.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_LAT; k++) pstage[k] <= '0;
        end else begin
            pstage[0] <= bus.pipe_valid ? aabb(bus.pipe_data) : '0;
            for (int k = 1; k < PIPE_LAT; k++) pstage[k] <= pstage[k-1];
        end
    end
    assign bus.pipe_hit    = pstage[PIPE_LAT-1][W];
    assign bus.pipe_t_near = pstage[PIPE_LAT-1][W-1:0];

    task automatic pop_check(input int i);
        int idx;
        logic [W:0] got;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].id == i) idx = k;
        if (idx < 0) begin
            check($sformatf("rsp_unexpected%0d", i), 64'(bus.rsp_valid[i]), 64'd0);
        end else begin
            got = {bus.rsp_hit[i], bus.rsp_t_near[i*W +: W]};
            check($sformatf("rsp_data%0d", i), 64'(got), 64'(sb[idx].v));
            sb.delete(idx);
        end
    endtask

    // Monitor: sampled mid-cycle; handshakes feed the scoreboard, pops are compared.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.req_ready != '0)
                check("ready_onehot",
                      64'($onehot(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)), 64'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb.push_back('{id: i, v: aabb(req_word[i])});
                    glog.push_back(i);
                    last_hs_cyc[i] = cyc;
                end
                if (bus.rsp_valid[i] && bus.rsp_ready[i]) pop_check(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] o, input logic [W-1:0] inv);
        req_word[i] = {o, o, o, inv, inv, inv, B0, B0, B0, B1, B1, B1};
    endtask

    task automatic wait_rsp(input int i, input string tag);
        int n;
        n = 0;
        while (!bus.rsp_valid[i] && n < 30) begin
            tick();
            n++;
        end
        if (!bus.rsp_valid[i]) check(tag, 64'(bus.rsp_valid[i]), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    function automatic int count_id(input int id);
        int c;
        c = 0;
        foreach (glog[k]) if (glog[k] == id) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_word;
        int            seen;
        rst           = 1'b1;
        enable        = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, '0, ONE);
        repeat (3) tick();
        check("rst_pipe_valid", 64'(bus.pipe_valid), 64'd0);
        check("rst_pipe_data", 64'(bus.pipe_data != '0), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_issue_count", 64'(issue_count), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        rst    = 1'b0;
        enable = 1'b1;
        tick();

        // T1: single hit on requester 0, latency and counters.
        bus.rsp_ready = '1;
        set_req(0, '0, ONE);
        exp_word = req_word[0];
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        check("t1_pipe_valid", 64'(bus.pipe_valid), 64'd1);
        check("t1_pipe_data", 64'(bus.pipe_data == exp_word), 64'd1);
        check("t1_issue_count", 64'(issue_count), 64'd1);
        wait_rsp(0, "t1_rsp_timeout");
        check("t1_latency", 64'(cyc - last_hs_cyc[0]), 64'd6);
        check("t1_hit", 64'(bus.rsp_hit[0]), 64'd1);
        check("t1_t_near", 64'(bus.rsp_t_near[W-1:0]), 64'h8000);
        check("t1_hit_count", 64'(hit_count), 64'd1);
        drain();

        // T2: miss on requester 2.
        set_req(2, '0, NEG_ONE);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        wait_rsp(2, "t2_rsp_timeout");
        check("t2_hit", 64'(bus.rsp_hit[2]), 64'd0);
        check("t2_other_valid", 64'(bus.rsp_valid & 4'b1011), 64'd0);
        check("t2_hit_count", 64'(hit_count), 64'd1);
        drain();

        // T3: all requesters valid, one grant per cycle in rotating order.
        glog.delete();
        bus.req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            set_req(0, 32'(k * 32'h800), ONE);
            set_req(1, 32'h4000 + 32'(k * 32'h400), TWO);
            set_req(2, 32'(k * 32'h100), NEG_ONE);
            set_req(3, 32'hC000 - 32'(k * 32'h200), ONE);
            tick();
        end
        bus.req_valid = '0;
        check("t3_grants", 64'(glog.size()), 64'd16);
        check("t3_first", 64'(glog[0]), 64'd3);
        for (int k = 1; k < glog.size(); k++)
            check("t3_order", 64'(glog[k]), 64'((glog[k-1] + 1) % NREQ));
        drain();

        // T4: requester 1 backpressured, requester 3 keeps issuing.
        glog.delete();
        bus.rsp_ready = 4'b1101;
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 16; k++) begin
            set_req(1, 32'(k * 32'h1000), ONE);
            set_req(3, 32'(k * 32'h300), TWO);
            tick();
        end
        check("t4_r1_grants", 64'(count_id(1)), 64'd2);
        check("t4_r3_issuing", 64'(count_id(3) >= 4), 64'd1);
        check("t4_r1_held", 64'(bus.rsp_valid[1]), 64'd1);
        glog.delete();
        bus.rsp_ready = '1;
        for (int k = 0; k < 12; k++) begin
            set_req(1, 32'h100 + 32'(k * 32'h1000), ONE);
            tick();
        end
        bus.req_valid = '0;
        check("t4_r1_resumed", 64'(count_id(1) >= 1), 64'd1);
        drain();

        // T5: enable low blocks grants; reset discards in-flight work.
        enable        = 1'b0;
        bus.req_valid = '1;
        tick();
        check("t5_ready_disabled", 64'(bus.req_ready), 64'd0);
        tick();
        check("t5_pipe_disabled", 64'(bus.pipe_valid), 64'd0);
        enable = 1'b1;
        repeat (3) tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy_after_rst", 64'(busy), 64'd0);
        check("t5_rsp_after_rst", 64'(bus.rsp_valid), 64'd0);
        check("t5_issue_after_rst", 64'(issue_count), 64'd0);
        check("t5_pipe_after_rst", 64'(bus.pipe_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.rsp_valid != '0) seen++;
        end
        check("t5_no_stale_rsp", 64'(seen), 64'd0);
        glog.delete();
        bus.req_valid = '1;
        tick();
        check("t5_ptr_zero", 64'(glog[0]), 64'd0);
        bus.rsp_ready = 4'b1110;
        bus.req_valid = 4'b0001;
        repeat (10) tick();
        bus.req_valid = '0;
        check("t5_credits_full", 64'(count_id(0)), 64'd2);
        bus.rsp_ready = '1;
        drain();

        // T6: push and pop on FIFO[0] in the same cycle.
        bus.rsp_ready = 4'b1110;
        set_req(0, 32'h1000, ONE);
        bus.req_valid = 4'b0001;
        tick();
        set_req(0, 32'h2000, ONE);
        tick();
        bus.req_valid = '0;
        wait_rsp(0, "t6_rsp_timeout");
        check("t6_head_first", 64'(bus.rsp_t_near[W-1:0]), 64'h7000);
        bus.rsp_ready = '1;
        tick();
        bus.rsp_ready = 4'b1110;
        check("t6_valid_after_swap", 64'(bus.rsp_valid[0]), 64'd1);
        check("t6_head_second", 64'(bus.rsp_t_near[W-1:0]), 64'h6000);
        tick();
        check("t6_occupancy_one", 64'(bus.rsp_valid[0]), 64'd1);
        bus.rsp_ready = '1;
        tick();
        check("t6_empty", 64'(bus.rsp_valid[0]), 64'd0);
        drain();

        check("sb_leftover", 64'(sb.size()), 64'd0);
        check("final_issue_count", 64'(issue_count), 64'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
